// File: rtl/sdram_cpu_bridge.sv
// sdram_cpu_bridge: CPU byte bus to SDRAM toggle port; optional read cache via SDRAM_CPU_BRIDGE_RDCACHE_EN
module sdram_cpu_bridge (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic [21:0] cpu_a,
  input  logic [7:0]  cpu_d,
  output logic [7:0]  cpu_q,
  output logic        cpu_q_valid,
  output logic        cpu_busy,
  input  logic        cache_flush,
  output logic        port_req,
  input  logic        port_ack,
  output logic        port_we,
  output logic [20:0] port_a,
  output logic [1:0]  port_ds,
  output logic [15:0] port_d,
  input  logic [15:0] port_q
);
  typedef enum logic [1:0] {SYNC, IDLE, RD, WR} state_t;
  state_t state_q, state_d;
  logic busy_q, busy_d, sync_q, sync_d, req_q, req_d, we_q, we_d, lane_q, lane_d, qv_q, qv_d;
  logic [20:0] a_q, a_d;
  logic [1:0] ds_q, ds_d;
  logic [15:0] d_q, d_d;
  logic [7:0] q_q, q_d;
  logic hit;
  logic [15:0] cache_data;
  logic done;
  assign done = port_ack == req_q;
`ifdef SDRAM_CPU_BRIDGE_RDCACHE_EN
  logic cv_q;
  logic [20:0] ctag_q;
  logic [15:0] cdata_q;
  assign cache_data = cdata_q;
  assign hit = cv_q && ctag_q == cpu_a[21:1] && !cache_flush;
  // cache: fill on read completion, merge posted writes to the cached word, flush clears valid
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cv_q <= 1'b0;
      ctag_q <= '0;
      cdata_q <= '0;
    end else begin
      if (state_q == RD && done) begin
        cv_q <= 1'b1;
        ctag_q <= a_q;
        cdata_q <= port_q;
      end else if (state_q == IDLE && cpu_wr && ctag_q == cpu_a[21:1]) begin
        if (cpu_a[0]) cdata_q[7:0] <= cpu_d;
        else cdata_q[15:8] <= cpu_d;
      end
      if (cache_flush) cv_q <= 1'b0;
    end
`else
  logic unused_flush;
  assign unused_flush = cache_flush;
  assign cache_data = '0;
  assign hit = 1'b0;
`endif
  // state and port registers
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= SYNC;
      busy_q <= 1'b1;
      sync_q <= 1'b0;
      req_q <= 1'b0;
      we_q <= 1'b0;
      lane_q <= 1'b0;
      qv_q <= 1'b0;
      a_q <= '0;
      ds_q <= '0;
      d_q <= '0;
      q_q <= '0;
    end else begin
      state_q <= state_d;
      busy_q <= busy_d;
      sync_q <= sync_d;
      req_q <= req_d;
      we_q <= we_d;
      lane_q <= lane_d;
      qv_q <= qv_d;
      a_q <= a_d;
      ds_q <= ds_d;
      d_q <= d_d;
      q_q <= q_d;
    end
  // next state: resync request level, issue requests, complete on matching ack
  always_comb begin
    state_d = state_q;
    busy_d = busy_q;
    sync_d = sync_q;
    req_d = req_q;
    we_d = we_q;
    lane_d = lane_q;
    qv_d = 1'b0;
    a_d = a_q;
    ds_d = ds_q;
    d_d = d_q;
    q_d = q_q;
    case (state_q)
      SYNC: begin
        sync_d = 1'b1;
        req_d = sync_q ? req_q : port_ack;
        state_d = sync_q ? IDLE : SYNC;
        busy_d = !sync_q;
      end
      IDLE:
        if (cpu_wr) begin
          a_d = cpu_a[21:1];
          ds_d = cpu_a[0] ? 2'b01 : 2'b10;
          d_d = {cpu_d, cpu_d};
          we_d = 1'b1;
          req_d = !req_q;
          busy_d = 1'b1;
          state_d = WR;
        end else if (cpu_rd && hit) begin
          q_d = cpu_a[0] ? cache_data[7:0] : cache_data[15:8];
          qv_d = 1'b1;
        end else if (cpu_rd) begin
          a_d = cpu_a[21:1];
          ds_d = 2'b11;
          we_d = 1'b0;
          lane_d = cpu_a[0];
          req_d = !req_q;
          busy_d = 1'b1;
          state_d = RD;
        end
      RD:
        if (done) begin
          q_d = lane_q ? port_q[7:0] : port_q[15:8];
          qv_d = 1'b1;
          busy_d = 1'b0;
          state_d = IDLE;
        end
      default:
        if (done) begin
          busy_d = 1'b0;
          state_d = IDLE;
        end
    endcase
  end
  assign cpu_q = q_q;
  assign cpu_q_valid = qv_q;
  assign cpu_busy = busy_q;
  assign port_req = req_q;
  assign port_we = we_q;
  assign port_a = a_q;
  assign port_ds = ds_q;
  assign port_d = d_q;
endmodule

// File: tb/tb_sdram_cpu_bridge.sv
// tb_sdram_cpu_bridge: directed bench for sdram_cpu_bridge (cache tests follow SDRAM_CPU_BRIDGE_RDCACHE_EN)
module tb_sdram_cpu_bridge;
  logic clk = 0, reset = 1, cpu_rd = 0, cpu_wr = 0, cache_flush = 0, port_ack = 1;
  logic [21:0] cpu_a = '0;
  logic [7:0] cpu_d = '0, cpu_q;
  logic cpu_q_valid, cpu_busy, port_req, port_we;
  logic [20:0] port_a;
  logic [1:0] port_ds;
  logic [15:0] port_d, port_q = '0;
  int n_cmp = 0, n_bad = 0;
  logic exp_req;
`ifdef SDRAM_CPU_BRIDGE_RDCACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif
  sdram_cpu_bridge dut (
    .clk(clk), .reset(reset), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_a(cpu_a), .cpu_d(cpu_d),
    .cpu_q(cpu_q), .cpu_q_valid(cpu_q_valid), .cpu_busy(cpu_busy), .cache_flush(cache_flush),
    .port_req(port_req), .port_ack(port_ack), .port_we(port_we), .port_a(port_a),
    .port_ds(port_ds), .port_d(port_d), .port_q(port_q)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic do_write(input logic [21:0] a, input logic [7:0] d, input logic [1:0] ds);
    cpu_wr = 1; cpu_a = a; cpu_d = d;
    tick;
    cpu_wr = 0;
    exp_req = ~exp_req;
    chk("wr_req", port_req, exp_req);
    chk("wr_a", port_a, a[21:1]);
    chk("wr_ds", port_ds, ds);
    chk("wr_d", port_d, {d, d});
    chk("wr_we", port_we, 1);
    chk("wr_busy", cpu_busy, 1);
    tick; tick;
    chk("wr_busy_wait", cpu_busy, 1);
    port_ack = exp_req;
    tick;
    chk("wr_done_busy", cpu_busy, 0);
    chk("wr_no_qv", cpu_q_valid, 0);
  endtask
  task automatic do_read(input logic [21:0] a, input logic fl, input logic [15:0] pq, input logic hit, input logic [7:0] q);
    cpu_rd = 1; cpu_a = a; cache_flush = fl;
    tick;
    cpu_rd = 0; cache_flush = 0;
    if (hit) begin
      chk("hit_qv", cpu_q_valid, 1);
      chk("hit_q", cpu_q, q);
      chk("hit_no_req", port_req, exp_req);
      chk("hit_busy", cpu_busy, 0);
    end else begin
      exp_req = ~exp_req;
      chk("rd_req", port_req, exp_req);
      chk("rd_busy", cpu_busy, 1);
      chk("rd_we", port_we, 0);
      chk("rd_ds", port_ds, 2'b11);
      chk("rd_a", port_a, a[21:1]);
      for (int i = 0; i < 4; i++) begin
        tick;
        chk("rd_wait_qv", cpu_q_valid, 0);
      end
      port_q = pq; port_ack = exp_req;
      tick;
      chk("rd_qv", cpu_q_valid, 1);
      chk("rd_q", cpu_q, q);
      chk("rd_busy_clr", cpu_busy, 0);
    end
    tick;
    chk("qv_pulse_end", cpu_q_valid, 0);
    chk("q_held", cpu_q, q);
  endtask
  initial begin
    tick; tick;
    chk("rst_busy", cpu_busy, 1);
    chk("rst_req", port_req, 0);
    chk("rst_qv", cpu_q_valid, 0);
    chk("rst_q", cpu_q, 0);
    chk("rst_port", {port_we, port_a, port_ds, port_d}, 0);
    reset = 0;
    tick;
    chk("sync_req", port_req, 1);
    chk("sync_busy", cpu_busy, 1);
    tick;
    chk("sync_busy_clr", cpu_busy, 0);
    chk("sync_no_req", port_req, 1);
    exp_req = 1;
    do_write(22'h000101, 8'hA5, 2'b01);
    do_read(22'h000100, 0, 16'h1234, 0, 8'h12);
    do_read(22'h000101, 0, 16'h1234, CACHE, 8'h34);
    do_write(22'h000101, 8'hEE, 2'b01);
    do_read(22'h000101, 0, 16'h12EE, CACHE, 8'hEE);
    do_read(22'h000101, 1, 16'h12EE, 0, 8'hEE);
    do_write(22'h000400, 8'h5A, 2'b10);
    do_read(22'h000100, 0, 16'h12EE, CACHE, 8'h12);
    cpu_rd = 1; cpu_a = 22'h000200;
    tick;
    exp_req = ~exp_req;
    chk("abort_req", port_req, exp_req);
    cpu_a = 22'h000300;
    tick;
    cpu_rd = 0;
    chk("busy_strobe_a", port_a, 21'h000100);
    chk("busy_strobe_req", port_req, exp_req);
    reset = 1;
    #1;
    chk("abort_busy", cpu_busy, 1);
    chk("abort_req_rst", port_req, 0);
    chk("abort_q", cpu_q, 0);
    chk("abort_port", {port_we, port_a, port_ds, port_d}, 0);
    port_q = 16'hBEEF; port_ack = exp_req;
    tick; tick;
    reset = 0;
    tick;
    chk("resync_req", port_req, exp_req);
    chk("resync_busy", cpu_busy, 1);
    chk("resync_qv", cpu_q_valid, 0);
    tick;
    chk("resync_busy_clr", cpu_busy, 0);
    chk("resync_qv2", cpu_q_valid, 0);
    tick;
    chk("resync_qv3", cpu_q_valid, 0);
    chk("resync_q", cpu_q, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
